// File: rtl/spi_master_arbiter.sv
// -----------------------------------------------------------------------------
// spi_master_arbiter
//
// Shares one SPI master FIFO interface between NumReq requesting apps.
// Round-robin arbitration; a grant is held for a whole transaction and is
// only released after the SPI master has drained (TX FIFO empty and no shift
// in progress). The grant is then re-arbitrated from IDLE.
//
// Optional feature macro: SPI_ARB_TIMEOUT_EN
//   When defined, a watchdog counts GRANT cycles. When the count reaches
//   TimeoutPreset_i (non-zero), TimeoutIRQ_o pulses for one cycle, the grant
//   is forced into DRAIN and that requester is blocked until its Req_i has
//   been seen low for at least one cycle. When undefined, TimeoutIRQ_o is 0
//   and TimeoutPreset_i is ignored.
//
// Ports
//   Clk_i, Reset_n_i       clock, asynchronous active-low reset
//   Req_i[NumReq]          per-requester bus request (held for a transaction)
//   Gnt_o[NumReq]          registered one-hot grant
//   ReqWrite_i/ReqReadNext_i/ReqData_i  per-requester FIFO strobes / TX byte
//   SPI_Write_o/SPI_ReadNext_o/SPI_DataIn_o  muxed to the SPI master (GRANT only)
//   SPI_DataOut_i, SPI_FIFOFull_i  broadcast to requesters outside this block
//   SPI_FIFOEmpty_i, SPI_Transmission_i  drain status of the SPI master
//   TimeoutPreset_i        watchdog limit in cycles (0 = watchdog off)
//   TimeoutIRQ_o           one-cycle watchdog pulse
// -----------------------------------------------------------------------------
module spi_master_arbiter #(
  parameter int NumReq       = 2,
  parameter int TimeoutWidth = 16
) (
  input  logic                    Clk_i,
  input  logic                    Reset_n_i,
  input  logic [NumReq-1:0]       Req_i,
  output logic [NumReq-1:0]       Gnt_o,
  input  logic [NumReq-1:0]       ReqWrite_i,
  input  logic [NumReq-1:0]       ReqReadNext_i,
  input  logic [8*NumReq-1:0]     ReqData_i,
  output logic                    SPI_Write_o,
  output logic                    SPI_ReadNext_o,
  output logic [7:0]              SPI_DataIn_o,
  input  logic [7:0]              SPI_DataOut_i,
  input  logic                    SPI_FIFOEmpty_i,
  input  logic                    SPI_FIFOFull_i,
  input  logic                    SPI_Transmission_i,
  input  logic [TimeoutWidth-1:0] TimeoutPreset_i,
  output logic                    TimeoutIRQ_o
);

  localparam int IdxW = $clog2(NumReq);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [NumReq-1:0] gnt_q, gnt_d;
  logic [IdxW-1:0]   last_q, last_d;   // most recently granted requester
  logic [NumReq-1:0] elig;             // requests allowed to compete
  logic              timeout_fire;
  logic              sel_valid;
  logic [IdxW-1:0]   sel_idx;
  logic [IdxW-1:0]   cand_idx [NumReq];

  // cand_idx[gi] is the requester at rotation distance gi+1 from last_q,
  // so cand_idx[0] has the highest priority and cand_idx[NumReq-1]
  // (== last_q) the lowest.
  generate
    for (genvar gi = 0; gi < NumReq; gi++) begin : g_cand
      logic [IdxW:0] sum;
      always_comb begin
        sum = {1'b0, last_q} + (IdxW+1)'(gi + 1);
        if (sum >= (IdxW+1)'(NumReq)) begin
          sum = sum - (IdxW+1)'(NumReq);
        end
      end
      assign cand_idx[gi] = sum[IdxW-1:0];
    end
  endgenerate

  // Scan from lowest to highest priority so the last hit wins.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = last_q;
    for (int i = NumReq - 1; i >= 0; i--) begin
      if (elig[cand_idx[i]]) begin
        sel_valid = 1'b1;
        sel_idx   = cand_idx[i];
      end
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  logic [TimeoutWidth-1:0] cnt_q, cnt_d;
  logic [NumReq-1:0]       blocked_q, blocked_d;

  // cnt_q holds the number of completed GRANT cycles, so the comparison
  // against cnt_q+1 fires during GRANT cycle number TimeoutPreset_i.
  assign timeout_fire = (state_q == GRANT) && (TimeoutPreset_i != '0) &&
                        ((cnt_q + TimeoutWidth'(1)) == TimeoutPreset_i);

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      cnt_d = '0;
    end else if (state_q == GRANT) begin
      cnt_d = cnt_q + TimeoutWidth'(1);
    end
  end

  // A block is kept only while the request stays high; one low cycle clears it.
  generate
    for (genvar gi = 0; gi < NumReq; gi++) begin : g_block
      assign blocked_d[gi] = (blocked_q[gi] |
                              (timeout_fire && (last_q == IdxW'(gi)))) & Req_i[gi];
    end
  endgenerate

  always_ff @(posedge Clk_i or negedge Reset_n_i) begin
    if (!Reset_n_i) begin
      cnt_q     <= '0;
      blocked_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      blocked_q <= blocked_d;
    end
  end

  assign elig         = Req_i & ~blocked_q;
  assign TimeoutIRQ_o = timeout_fire;

  logic unused_inputs;
  assign unused_inputs = ^{SPI_DataOut_i, SPI_FIFOFull_i};
`else
  assign timeout_fire = 1'b0;
  assign elig         = Req_i;
  assign TimeoutIRQ_o = 1'b0;

  logic unused_inputs;
  assign unused_inputs = ^{SPI_DataOut_i, SPI_FIFOFull_i, TimeoutPreset_i};
`endif

  // State register
  always_ff @(posedge Clk_i or negedge Reset_n_i) begin
    if (!Reset_n_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= IdxW'(NumReq - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (sel_valid) begin
          state_d          = GRANT;
          gnt_d            = '0;
          gnt_d[sel_idx]   = 1'b1;
          last_d           = sel_idx;
        end
      end
      GRANT: begin
        if (!Req_i[last_q] || timeout_fire) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!SPI_Transmission_i && SPI_FIFOEmpty_i) begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // SPI side: pass-through of the granted requester, zero otherwise.
  always_comb begin
    SPI_Write_o    = 1'b0;
    SPI_ReadNext_o = 1'b0;
    SPI_DataIn_o   = 8'h00;
    if (state_q == GRANT) begin
      SPI_Write_o    = ReqWrite_i[last_q];
      SPI_ReadNext_o = ReqReadNext_i[last_q];
      SPI_DataIn_o   = ReqData_i[{last_q, 3'b000} +: 8];
    end
  end

  assign Gnt_o = gnt_q;

endmodule
